cache_refill_ctrl: RTL and testbench

- Miss-handling controller that sits between the CPU-side request stream and the baseCache-based cache instances (cache_direct_*).
- Looks up each request in the cache.
- On a read miss it fetches the block from main memory over a valid/ready port, refills the cache, then responds.
- Writes are write-through, no-write-allocate.
- Hit and miss counters support the cache-size/block-size performance experiments.

---
 rtl/cache_refill_ctrl_pkg.sv | 24 ++
 rtl/cache_perf_cnt.sv | 27 ++
 rtl/cache_refill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared FSM encoding and address-offset helper
package cache_refill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_REFILL    = 3'd4,
        ST_WT_REQ    = 3'd5,
        ST_RESP      = 3'd6
    } state_t;

    // Number of byte-offset bits inside a block (block sizes 1..8 bytes).
    function automatic int offset_bits(input int block_bytes);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) < block_bytes) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// rtl/cache_perf_cnt.sv - saturating performance counter with synchronous clear
module cache_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - read-miss refill, write-through cache controller
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_BYTES = 4,
    parameter int BLOCK_WIDTH = BLOCK_BYTES * 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_wr,
    input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
    input  logic [BLOCK_WIDTH-1:0] cpu_req_wdata,
    output logic                   cpu_rsp_valid,
    output logic [BLOCK_WIDTH-1:0] cpu_rsp_rdata,
    output logic                   cache_wr,
    output logic [ADDR_WIDTH-1:0]  cache_addr,
    output logic [BLOCK_WIDTH-1:0] cache_din,
    input  logic [BLOCK_WIDTH-1:0] cache_dout,
    input  logic                   cache_hit,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_wr,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    output logic [BLOCK_WIDTH-1:0] mem_req_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [BLOCK_WIDTH-1:0] mem_rsp_data,
    input  logic                   clr_cnt,
    output logic [CNT_WIDTH-1:0]   hit_cnt,
    output logic [CNT_WIDTH-1:0]   miss_cnt
);

    localparam int OFF_W = offset_bits(BLOCK_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic [BLOCK_WIDTH-1:0] r_data;
    logic                   w_hit_inc;
    logic                   w_miss_inc;
    logic [ADDR_WIDTH-1:0]  w_aligned;

    assign w_aligned = r_addr & ALIGN_MASK;

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and read-data capture (from cache on hit, from memory on refill).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == ST_IDLE && cpu_req_valid) begin
                r_wr    <= cpu_req_wr;
                r_addr  <= cpu_req_addr;
                r_wdata <= cpu_req_wdata;
            end
            if (r_state == ST_LOOKUP && !r_wr && cache_hit) begin
                r_data <= cache_dout;
            end
            if (r_state == ST_MISS_WAIT && mem_rsp_valid) begin
                r_data <= mem_rsp_data;
            end
        end
    end

    // Next-state and Moore/Mealy outputs; every output idles at 0.
    always_comb begin
        w_next        = r_state;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rsp_rdata = '0;
        cache_wr      = 1'b0;
        cache_addr    = '0;
        cache_din     = '0;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                cache_addr = r_addr;
                if (cache_hit) begin
                    w_hit_inc = 1'b1;
                    if (r_wr) begin
                        cache_wr  = 1'b1;
                        cache_din = r_wdata;
                        w_next    = ST_WT_REQ;
                    end else begin
                        w_next = ST_RESP;
                    end
                end else begin
                    // No-write-allocate: a write miss goes straight to memory.
                    w_miss_inc = 1'b1;
                    w_next     = r_wr ? ST_WT_REQ : ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_aligned;
                if (mem_req_ready) w_next = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (mem_rsp_valid) w_next = ST_REFILL;
            end
            ST_REFILL: begin
                cache_wr   = 1'b1;
                cache_addr = r_addr;
                cache_din  = r_data;
                w_next     = ST_RESP;
            end
            ST_WT_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = 1'b1;
                mem_req_addr  = w_aligned;
                mem_req_wdata = r_wdata;
                if (mem_req_ready) w_next = ST_RESP;
            end
            ST_RESP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_rdata = r_wr ? '0 : r_data;
                w_next        = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    cache_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_hit_inc),
        .i_clr (clr_cnt),
        .o_cnt (hit_cnt)
    );

    cache_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_miss_inc),
        .i_clr (clr_cnt),
        .o_cnt (miss_cnt)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - scoreboard bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_wr = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        cache_wr;
    logic [31:0] cache_addr;
    logic [31:0] cache_din;
    logic [31:0] cache_dout;
    logic        cache_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        clr_cnt = 1'b0;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    cache_refill_ctrl #(
        .ADDR_WIDTH(32), .BLOCK_BYTES(4), .BLOCK_WIDTH(32), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cache_wr(cache_wr), .cache_addr(cache_addr), .cache_din(cache_din),
        .cache_dout(cache_dout), .cache_hit(cache_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .clr_cnt(clr_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct { logic [31:0] rdata; int hits; int misses; bit lat_chk; int acc; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
    rsp_t  exp_q[$];
    mreq_t mexp_q[$];

    // Reference model: coherent memory plus a 4-line direct-mapped presence map.
    logic [31:0] mmem[int];
    bit          mv[4];
    int          mt[4];
    int          m_hits = 0;
    int          m_misses = 0;

    // Environment: main memory and the cache array the DUT manipulates.
    logic [31:0] emem[int];
    logic        ec_v[4];
    logic [27:0] ec_t[4];
    logic [31:0] ec_d[4];
    logic        clr_ec = 1'b1;
    logic        pre_en = 1'b0;
    logic [29:0] pre_blk = '0;
    logic [31:0] pre_data = '0;
    int          force_wait = -1;
    int          force_dly = -1;

    function automatic logic [31:0] init_val(input int b);
        return 32'(b) * 32'h9E3779B1 + 32'h1234;
    endfunction
    function automatic logic [31:0] model_rd(input int b);
        return mmem.exists(b) ? mmem[b] : init_val(b);
    endfunction
    function automatic logic [31:0] env_rd(input int b);
        return emem.exists(b) ? emem[b] : init_val(b);
    endfunction
    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    assign cache_hit  = ec_v[cache_addr[3:2]] && (ec_t[cache_addr[3:2]] == cache_addr[31:4]);
    assign cache_dout = ec_d[cache_addr[3:2]];

    always @(posedge clk) begin
        if (clr_ec) begin
            for (int i = 0; i < 4; i++) ec_v[i] <= 1'b0;
        end else if (pre_en) begin
            ec_v[pre_blk[1:0]] <= 1'b1;
            ec_t[pre_blk[1:0]] <= pre_blk[29:2];
            ec_d[pre_blk[1:0]] <= pre_data;
        end else if (cache_wr) begin
            ec_v[cache_addr[3:2]] <= 1'b1;
            ec_t[cache_addr[3:2]] <= cache_addr[31:4];
            ec_d[cache_addr[3:2]] <= cache_din;
        end
    end

    // Monitor: pop and compare on every CPU response strobe.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cpu_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, cpu_rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", cpu_rsp_rdata, e.rdata);
                    chk("hit_cnt", 32'(hit_cnt), 32'(e.hits));
                    chk("miss_cnt", 32'(miss_cnt), 32'(e.misses));
                    if (e.lat_chk) chk("hit_latency", 32'(cyc - e.acc), 32'd2);
                end
            end
        end
    end

    // Memory responder: random ready stalls, random read latency, request checking.
    initial begin
        int wcnt, wlim, pdly;
        bit in_req, pend;
        logic [31:0] s_addr, s_wdata, pdata;
        logic s_wr;
        mreq_t m;
        wcnt = 0; wlim = 0; pdly = 0; in_req = 0; pend = 0;
        s_addr = '0; s_wdata = '0; s_wr = 1'b0; pdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pend) begin
                if (pdly == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pdata;
                    pend = 0;
                end else begin
                    pdly--;
                end
            end
            if (mem_req_valid && rst_n) begin
                if (!in_req) begin
                    in_req = 1; wcnt = 0;
                    wlim = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
                    s_addr = mem_req_addr; s_wdata = mem_req_wdata; s_wr = mem_req_wr;
                end else begin
                    chk("mem_addr_stable", mem_req_addr, s_addr);
                    chk("mem_wr_stable", {31'd0, mem_req_wr}, {31'd0, s_wr});
                    chk("mem_wdata_stable", mem_req_wdata, s_wdata);
                end
                if (wcnt >= wlim) begin
                    mem_req_ready = 1'b1;
                    in_req = 0;
                    if (mexp_q.size() == 0) begin
                        chk("mem_req_unexpected", {31'd0, mem_req_valid}, 32'd0);
                    end else begin
                        m = mexp_q.pop_front();
                        chk("mem_req_addr", mem_req_addr, m.addr);
                        chk("mem_req_wr", {31'd0, mem_req_wr}, {31'd0, m.wr});
                        if (m.wr) chk("mem_req_wdata", mem_req_wdata, m.wdata);
                    end
                    if (mem_req_wr) begin
                        emem[int'(mem_req_addr >> 2)] = mem_req_wdata;
                    end else begin
                        pend  = 1;
                        pdly  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                        pdata = env_rd(int'(mem_req_addr >> 2));
                    end
                end else begin
                    mem_req_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_req_ready = 1'b0;
                in_req = 0;
            end
        end
    end

    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input bit clr_lk);
        int n, b, idx, tg;
        bit hit;
        rsp_t e;
        mreq_t m;
        n = 0;
        @(negedge clk);
        while (!cpu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) begin
            chk("req_ready_timeout", {31'd0, cpu_req_ready}, 32'd1);
            return;
        end
        cpu_req_valid = 1'b1; cpu_req_wr = wr; cpu_req_addr = addr; cpu_req_wdata = wdata;
        b = int'(addr >> 2); idx = b % 4; tg = b / 4;
        hit = mv[idx] && (mt[idx] == tg);
        if (hit) m_hits = sat(m_hits + 1);
        else     m_misses = sat(m_misses + 1);
        if (clr_lk) begin m_hits = 0; m_misses = 0; end
        m.addr = addr & ~32'd3;
        if (wr) begin
            mmem[b] = wdata;
            m.wr = 1; m.wdata = wdata;
            mexp_q.push_back(m);
            e.rdata = '0;
        end else begin
            e.rdata = model_rd(b);
            if (!hit) begin
                mv[idx] = 1; mt[idx] = tg;
                m.wr = 0; m.wdata = '0;
                mexp_q.push_back(m);
            end
        end
        e.hits = m_hits; e.misses = m_misses; e.lat_chk = !wr && hit; e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (clr_lk) begin
            clr_cnt = 1'b1;
            @(negedge clk);
            clr_cnt = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cpu_req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_clr();
        drain();
        clr_cnt = 1'b1; m_hits = 0; m_misses = 0;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic preload(input int b, input logic [31:0] d, input bit to_cache);
        drain();
        mmem[b] = d; emem[b] = d;
        if (to_cache) begin
            mv[b % 4] = 1; mt[b % 4] = b / 4;
            pre_blk = 30'(b); pre_data = d; pre_en = 1'b1;
            @(negedge clk);
            pre_en = 1'b0;
        end
    endtask

    initial begin
        int n;
        int r;
        for (int i = 0; i < 4; i++) begin mv[i] = 0; mt[i] = 0; end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, cpu_rsp_valid}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_cache_wr", {31'd0, cache_wr}, 32'd0);
        chk("rst_cache_addr", cache_addr, 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst_n = 1'b1; clr_ec = 1'b0;

        // Reset while waiting for memory data; the late response must be ignored.
        force_wait = 0; force_dly = 6;
        send(0, 32'h30, '0, 0);
        n = 0;
        while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
        while (mem_req_valid && n < 50) begin @(negedge clk); n++; end
        chk("reset_test_reach_wait", 32'(n < 50), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); mexp_q.delete();
        m_hits = 0; m_misses = 0;
        for (int i = 0; i < 4; i++) mv[i] = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("post_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        force_wait = -1; force_dly = -1;

        // Read hit.
        preload(32'h40, 32'hDEADBEEF, 1);
        send(0, 32'h100, '0, 0);
        // Read miss with 3-cycle ready stall, then hit on the refilled block.
        preload(32'h80, 32'h12345678, 0);
        force_wait = 3; force_dly = 0;
        send(0, 32'h203, '0, 0);
        drain();
        force_wait = -1; force_dly = -1;
        send(0, 32'h200, '0, 0);
        // Write hit, then read back through the cache.
        preload(32'h10, 32'h0BAD0BAD, 1);
        send(1, 32'h40, 32'hA5A5A5A5, 0);
        send(0, 32'h40, '0, 0);
        // Write miss: no allocation, so the following read misses and sees memory.
        send(1, 32'h54, 32'h5EED5EED, 0);
        send(0, 32'h54, '0, 0);

        // Hit counter saturation, then clear coinciding with a hit.
        idle_clr();
        preload(32'h40, 32'hDEADBEEF, 1);
        for (int i = 0; i < CMAX + 3; i++) send(0, 32'h100, '0, 0);
        send(0, 32'h100, '0, 1);

        // Random traffic over a small address window.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) idle_clr();
            send(($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)), $urandom, 0);
        end

        drain();
        repeat (5) @(negedge clk);
        chk("final_rsp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_mem_queue_empty", 32'(mexp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
